// File: rtl/eq_gain_scheduler.sv
// eq_gain_scheduler: holds per-band target gains written over a valid/ready
// port, ramps the live EQ gain bus one LSB per ramp interval, and commits
// each ramp step atomically through a band-by-band shadow sweep.
module eq_gain_scheduler #(
    parameter int NUMBER_OF_FILTERS = 10,
    parameter int GAIN_BITS         = 4,
    parameter int BAND_BITS         = 4,
    parameter int RAMP_DIV          = 4,
    parameter int RESET_GAIN        = 1
) (
    input  logic                                   i_clk,
    input  logic                                   i_reset,
    input  logic                                   i_sample_tick,
    input  logic                                   i_wr_valid,
    output logic                                   o_wr_ready,
    input  logic [BAND_BITS-1:0]                   i_wr_band,
    input  logic [GAIN_BITS-1:0]                   i_wr_gain,
    input  logic                                   i_mute,
    input  logic                                   i_clr_err,
    output logic [NUMBER_OF_FILTERS*GAIN_BITS-1:0] o_gain_out,
    output logic                                   o_eq_en,
    output logic                                   o_settled,
    output logic                                   o_busy,
    output logic [1:0]                             o_err
);

    localparam int                   DIV_W      = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [DIV_W-1:0]     DIV_LAST   = DIV_W'(RAMP_DIV - 1);
    localparam logic [GAIN_BITS-1:0] RST_GAIN   = GAIN_BITS'(RESET_GAIN);
    localparam logic [BAND_BITS-1:0] LAST_BAND  = BAND_BITS'(NUMBER_OF_FILTERS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        COMMIT
    } state_t;

    state_t               r_state;
    logic [GAIN_BITS-1:0] r_target [NUMBER_OF_FILTERS];
    logic [GAIN_BITS-1:0] r_shadow [NUMBER_OF_FILTERS];
    logic [GAIN_BITS-1:0] r_live   [NUMBER_OF_FILTERS];
    logic [DIV_W-1:0]     r_div_cnt;
    logic [BAND_BITS-1:0] r_band;
    logic                 r_eq_en;
    logic                 r_settled;
    logic [1:0]           r_err;

    logic [GAIN_BITS-1:0] w_target_nxt [NUMBER_OF_FILTERS];
    logic [GAIN_BITS-1:0] w_live_nxt   [NUMBER_OF_FILTERS];
    logic                 w_settled_nxt;
    logic                 w_wr_fire;
    logic                 w_band_ok;
    logic                 w_bad_wr;
    logic                 w_overrun;
    logic [GAIN_BITS-1:0] w_eff_target;
    logic [GAIN_BITS-1:0] w_cur_gain;
    logic [GAIN_BITS-1:0] w_step_gain;

    // Writes are only accepted in IDLE; reset holds the port closed.
    assign o_wr_ready = (r_state == IDLE) && !i_reset;
    assign o_busy     = (r_state != IDLE);
    assign o_eq_en    = r_eq_en;
    assign o_settled  = r_settled;
    assign o_err      = r_err;

    assign w_wr_fire = i_wr_valid && o_wr_ready;
    assign w_band_ok = (i_wr_band <= LAST_BAND);
    assign w_bad_wr  = w_wr_fire && !w_band_ok;
    assign w_overrun = i_sample_tick && (r_state != IDLE);

    // Flatten the live gains onto the packed bus, band i at [i*GAIN_BITS +: GAIN_BITS].
    for (genvar g = 0; g < NUMBER_OF_FILTERS; g++) begin : g_pack
        assign o_gain_out[g*GAIN_BITS +: GAIN_BITS] = r_live[g];
    end

    // One-LSB step of the band under sweep toward its effective target; never overshoots, so never wraps.
    always_comb begin
        w_eff_target = i_mute ? '0 : r_target[r_band];
        w_cur_gain   = r_live[r_band];
        if (w_cur_gain < w_eff_target) begin
            w_step_gain = w_cur_gain + 1'b1;
        end else if (w_cur_gain > w_eff_target) begin
            w_step_gain = w_cur_gain - 1'b1;
        end else begin
            w_step_gain = w_cur_gain;
        end
    end

    // Next target/live arrays, so settled can be judged on the values they are about to hold.
    always_comb begin
        // NOTE: every output gets a default before any conditional update, so no latch is inferred.
        w_target_nxt = r_target;
        w_live_nxt   = r_live;
        if (w_wr_fire && w_band_ok) begin
            w_target_nxt[i_wr_band] = i_wr_gain;
        end
        if (r_state == COMMIT) begin
            w_live_nxt = r_shadow;
        end
    end

    // Settled when every next live gain equals its next effective target.
    always_comb begin
        w_settled_nxt = 1'b1;
        for (int i = 0; i < NUMBER_OF_FILTERS; i++) begin
            if (w_live_nxt[i] != (i_mute ? '0 : w_target_nxt[i])) begin
                w_settled_nxt = 1'b0;
            end
        end
    end

    // Sequencer FSM with ramp divider, sweep/commit, error flags and eq_en.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_div_cnt <= '0;
            r_band    <= '0;
            r_eq_en   <= 1'b0;
            r_settled <= 1'b1;
            r_err     <= 2'b00;
            // NOTE: the gain arrays are reset on purpose: the EQ must start from a known gain,
            // and a reset mid-sweep must throw away the partial shadow.
            for (int i = 0; i < NUMBER_OF_FILTERS; i++) begin
                r_target[i] <= RST_GAIN;
                r_shadow[i] <= RST_GAIN;
                r_live[i]   <= RST_GAIN;
            end
        end else begin
            // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
            r_eq_en   <= i_sample_tick;
            r_target  <= w_target_nxt;
            r_live    <= w_live_nxt;
            r_settled <= w_settled_nxt;
            r_err     <= (i_clr_err ? 2'b00 : r_err) | {w_bad_wr, w_overrun};
            case (r_state)
                IDLE: begin
                    if (i_sample_tick) begin
                        if (r_div_cnt == DIV_LAST) begin
                            r_div_cnt <= '0;
                            r_band    <= '0;
                            r_state   <= SWEEP;
                        end else begin
                            r_div_cnt <= r_div_cnt + 1'b1;
                        end
                    end
                end
                SWEEP: begin
                    r_shadow[r_band] <= w_step_gain;
                    if (r_band == LAST_BAND) begin
                        r_state <= COMMIT;
                    end else begin
                        r_band <= r_band + 1'b1;
                    end
                end
                COMMIT: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eq_gain_scheduler.sv
// Directed bench for eq_gain_scheduler: one instance with RAMP_DIV=1 and one
// with RAMP_DIV=4 share all stimulus; a vector table drives ramp steps.
module tb_eq_gain_scheduler;

    localparam int N = 10;
    localparam int G = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         sample_tick;
    logic         wr_valid;
    logic [3:0]   wr_band;
    logic [3:0]   wr_gain;
    logic         mute;
    logic         clr_err;

    logic         wr_ready1, eq_en1, settled1, busy1;
    logic [1:0]   err1;
    logic [N*G-1:0] gain1;
    logic         wr_ready4, eq_en4, settled4, busy4;
    logic [1:0]   err4;
    logic [N*G-1:0] gain4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    eq_gain_scheduler #(.RAMP_DIV(1)) u_dut1 (
        .i_clk(clk), .i_reset(reset), .i_sample_tick(sample_tick),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready1), .i_wr_band(wr_band),
        .i_wr_gain(wr_gain), .i_mute(mute), .i_clr_err(clr_err),
        .o_gain_out(gain1), .o_eq_en(eq_en1), .o_settled(settled1),
        .o_busy(busy1), .o_err(err1)
    );

    eq_gain_scheduler #(.RAMP_DIV(4)) u_dut4 (
        .i_clk(clk), .i_reset(reset), .i_sample_tick(sample_tick),
        .i_wr_valid(wr_valid), .o_wr_ready(wr_ready4), .i_wr_band(wr_band),
        .i_wr_gain(wr_gain), .i_mute(mute), .i_clr_err(clr_err),
        .o_gain_out(gain4), .o_eq_en(eq_en4), .o_settled(settled4),
        .o_busy(busy4), .o_err(err4)
    );

    typedef struct {
        logic        wr;
        logic [3:0]  band;
        logic [3:0]  gain;
        logic        mute;
        logic [39:0] exp_gain;
        logic        exp_settled;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [3:0] band, input logic [3:0] gain);
        wr_valid = 1'b1;
        wr_band  = band;
        wr_gain  = gain;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic tick_pulse();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
    endtask

    task automatic clear_err();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
    endtask

    initial begin
        // Table starts from: band3 live 2 / target 4, all other bands 1.
        vecs[0] = '{1'b1, 4'd3, 4'd4, 1'b0, 40'h1111113111, 1'b0};
        vecs[1] = '{1'b1, 4'd3, 4'd4, 1'b0, 40'h1111114111, 1'b1};
        vecs[2] = '{1'b1, 4'd9, 4'd0, 1'b0, 40'h0111114111, 1'b1};
        vecs[3] = '{1'b1, 4'd0, 4'd3, 1'b1, 40'h0000003000, 1'b0};
        vecs[4] = '{1'b0, 4'd0, 4'd0, 1'b1, 40'h0000002000, 1'b0};
        vecs[5] = '{1'b0, 4'd0, 4'd0, 1'b0, 40'h0111113111, 1'b0};
        vecs[6] = '{1'b0, 4'd0, 4'd0, 1'b0, 40'h0111114112, 1'b0};
        vecs[7] = '{1'b0, 4'd0, 4'd0, 1'b0, 40'h0111114113, 1'b1};

        reset = 1'b1; sample_tick = 1'b0; wr_valid = 1'b0; wr_band = '0;
        wr_gain = '0; mute = 1'b0; clr_err = 1'b0;
        repeat (3) step();
        reset = 1'b0;

        // Idle after reset.
        repeat (20) step();
        check("rst_gain", gain1, 40'h1111111111);
        check("rst_settled", settled1, 1'b1);
        check("rst_wr_ready", wr_ready1, 1'b1);
        check("rst_err", err1, 2'b00);
        check("rst_busy", busy1, 1'b0);
        check("rst_eq_en", eq_en1, 1'b0);
        check("rst_gain4", gain4, 40'h1111111111);

        // First ramp step with cycle-accurate timing.
        write(4'd3, 4'd4);
        check("settled_drop_wr", settled1, 1'b0);
        tick_pulse();
        check("eq_en_pulse", eq_en1, 1'b1);
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 1) check("eq_en_one_cycle", eq_en1, 1'b0);
            check("sweep_busy", busy1, 1'b1);
            check("sweep_wr_ready", wr_ready1, 1'b0);
            check("sweep_gain_hold", gain1, 40'h1111111111);
        end
        step();
        check("commit_gain", gain1, 40'h1111112111);
        check("commit_busy", busy1, 1'b0);
        check("commit_wr_ready", wr_ready1, 1'b1);
        check("commit_settled", settled1, 1'b0);

        // Vector table: optional write, mute level, one ramp step.
        for (int r = 0; r < 8; r++) begin
            mute = vecs[r].mute;
            if (vecs[r].wr) write(vecs[r].band, vecs[r].gain);
            tick_pulse();
            repeat (12) step();
            check($sformatf("vec%0d_gain", r), gain1, vecs[r].exp_gain);
            check($sformatf("vec%0d_settled", r), settled1, vecs[r].exp_settled);
            check($sformatf("vec%0d_err", r), err1, 2'b00);
        end

        // Mute toggles settled on the following cycle.
        mute = 1'b1;
        step();
        check("settled_mute_on", settled1, 1'b0);
        mute = 1'b0;
        step();
        check("settled_mute_off", settled1, 1'b1);

        // Write and sweep-starting tick in the same cycle: sweep uses the new target.
        wr_valid = 1'b1; wr_band = 4'd1; wr_gain = 4'd2; sample_tick = 1'b1;
        step();
        wr_valid = 1'b0; sample_tick = 1'b0;
        repeat (12) step();
        check("wr_tick_same_cycle", gain1, 40'h0111114123);

        // Bad band index.
        check("bad_wr_ready", wr_ready1, 1'b1);
        write(4'd12, 4'd7);
        check("bad_err", err1, 2'b10);
        repeat (13) step();
        check("bad_gain_hold", gain1, 40'h0111114123);
        clear_err();
        check("clr_err", err1, 2'b00);
        clr_err = 1'b1;
        write(4'd12, 4'd7);
        clr_err = 1'b0;
        check("clr_vs_new_err", err1, 2'b10);
        clear_err();

        // Tick overrun during a sweep.
        tick_pulse();
        repeat (4) step();
        tick_pulse();
        check("overrun_err", err1, 2'b01);
        check("overrun_eq_en", eq_en1, 1'b1);
        check("overrun_busy", busy1, 1'b1);
        repeat (12) step();
        clear_err();
        check("overrun_clr", err1, 2'b00);

        // Reset mid-sweep discards the partial shadow.
        write(4'd0, 4'd5);
        tick_pulse();
        repeat (4) step();
        check("mid_sweep_busy", busy1, 1'b1);
        reset = 1'b1;
        step();
        check("mid_rst_gain", gain1, 40'h1111111111);
        check("mid_rst_wr_ready", wr_ready1, 1'b0);
        check("mid_rst_busy", busy1, 1'b0);
        check("mid_rst_settled", settled1, 1'b1);
        reset = 1'b0;
        #1;
        check("post_rst_wr_ready", wr_ready1, 1'b1);
        repeat (15) step();
        check("post_rst_gain", gain1, 40'h1111111111);

        // RAMP_DIV=4: only every 4th idle tick sweeps; eq_en follows every tick.
        write(4'd0, 4'd0);
        for (int t = 1; t <= 3; t++) begin
            tick_pulse();
            check($sformatf("div4_eq_en_t%0d", t), eq_en4, 1'b1);
            step();
            check($sformatf("div4_eq_en_low_t%0d", t), eq_en4, 1'b0);
            repeat (13) step();
            check($sformatf("div4_hold_t%0d", t), gain4, 40'h1111111111);
        end
        tick_pulse();
        repeat (5) step();
        tick_pulse();
        check("div4_overrun_err", err4, 2'b01);
        repeat (12) step();
        check("div4_step_down", gain4, 40'h1111111110);
        clear_err();

        // The overrun tick must not have advanced the divider.
        write(4'd0, 4'd1);
        for (int t = 1; t <= 3; t++) begin
            tick_pulse();
            repeat (14) step();
            check($sformatf("div4_ignore_busy_t%0d", t), gain4, 40'h1111111110);
        end
        tick_pulse();
        repeat (14) step();
        check("div4_step_up", gain4, 40'h1111111111);
        check("div4_settled", settled4, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
